alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  Pipeline stage directly downstream of the general purpose registers. Captures LHSBus/RHSBus
//  operands plus ALU opcode when the register stage drives them and presents them to the ALU.
//  A 2-entry skid buffer absorbs ALU back-pressure. Held entries snoop the writeback path so
//  operands stay current while stalled.
// PARAMETERS
//  WIDTH  8  operand width (LHS/RHS bus width)
//  OPW    4  ALU opcode width
//  REGW   2  register-id width (4 GPRs)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active high
//  lhs_bus    in   WIDTH  LHSBus value driven by selected GPR this cycle
//  rhs_bus    in   WIDTH  RHSBus value driven by selected GPR this cycle
//  in_op      in   OPW    ALU opcode accompanying the operands
//  in_lhs_id  in   REGW   GPR id driving lhs_bus
//  in_rhs_id  in   REGW   GPR id driving rhs_bus
//  in_valid   in   1      operands/op valid this cycle
//  in_ready   out  1      stage accepts; transfer when in_valid & in_ready
//  wb_valid   in   1      GPR load (load_n active) occurs at the next edge
//  wb_id      in   REGW   GPR being loaded
//  wb_data    in   WIDTH  value being loaded (MainBus)
//  flush      in   1      discard all held and incoming entries
//  out_valid  out  1      out_* valid for ALU
//  out_ready  in   1      ALU accepts; transfer when out_valid & out_ready
//  out_lhs    out  WIDTH  registered LHS operand
//  out_rhs    out  WIDTH  registered RHS operand
//  out_op     out  OPW    registered opcode
// BEHAVIOUR
//  - Storage: output slot O (drives out_*) and skid slot S. Each slot holds {lhs,rhs,op,lhs_id,rhs_id}.
//  - States: EMPTY (O,S invalid), ONE (O valid), TWO (O,S valid). push = in_valid&in_ready;
//    pop = out_valid&out_ready.
//    EMPTY: push -> ONE (entry into O).
//    ONE: push&!pop -> TWO (entry into S); push&pop -> ONE (entry into O); !push&pop -> EMPTY.
//    TWO: pop -> ONE (S moves to O); !pop -> TWO. No push possible (in_ready=0).
//  - in_ready registered: 1 in EMPTY/ONE, 0 in TWO. out_valid = (state!=EMPTY), registered.
//  - Latency: push at edge N -> out_valid from cycle N+1 when EMPTY. Full throughput (1/cycle)
//    when out_ready held high. Order is strictly FIFO; no entry dropped or duplicated.
//  - Capture forwarding: on push, lhs = (wb_valid & wb_id==in_lhs_id) ? wb_data : lhs_bus; same for rhs.
//  - Snoop: every edge with wb_valid, any slot that stays or moves (not popped) with matching
//    lhs_id/rhs_id takes wb_data for that operand. Both operands match same id -> both updated.
//  - Popped entry is consumed with its pre-edge value; a same-cycle writeback does not alter it.
//  - flush: at edge, state->EMPTY, in_ready->1, incoming push ignored, pop treated as done.
//    flush has priority over push/pop/snoop.
//  - rst (priority over flush): state EMPTY; out_valid=0; in_ready=1; out_lhs=out_rhs=0; out_op=0;
//    S contents=0. Reset mid-operation discards all entries. Entries accepted in the reset cycle are lost.
//  - Slot data unchanged when not written; out_* stable while out_valid & !out_ready (except snoop).
//  - Widths: pure storage, no arithmetic; ids compared full REGW bits.
// TESTING
//  1 rst 2 cycles -> out_valid=0, in_ready=1, out_lhs=out_rhs=0, out_op=0.
//  2 out_ready=1; push (lhs 0x12,rhs 0x34,op 3), then (0x56,0x78,op 5) -> out 0x12/0x34/3 at N+1,
//    0x56/0x78/5 at N+2; in_ready stays 1.
//  3 out_ready=0; push A=0x01, B=0x02 -> in_ready=0 after 2nd edge; out holds A; raise out_ready
//    -> A, B in order, in_ready=1 next cycle.
//  4 push lhs_id=2 lhs_bus=0x10 with wb_valid wb_id=2 wb_data=0xAA -> out_lhs=0xAA.
//  5 state TWO, stalled, S lhs_id=1, O rhs_id=1; wb_valid wb_id=1 wb_data=0x5C -> O.rhs=0x5C, S.lhs=0x5C.
//  6 state TWO; flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, no stale entry emitted.

Source files
------------

// File: rtl/alu_operand_stage.sv
// Operand/opcode capture stage between the GPR file and the ALU.
// Two-entry skid buffer; held operands track GPR writebacks while stalled.
module alu_operand_stage #(
    parameter int WIDTH = 8,
    parameter int OPW   = 4,
    parameter int REGW  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] lhs_bus,
    input  logic [WIDTH-1:0] rhs_bus,
    input  logic [OPW-1:0]   in_op,
    input  logic [REGW-1:0]  in_lhs_id,
    input  logic [REGW-1:0]  in_rhs_id,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             wb_valid,
    input  logic [REGW-1:0]  wb_id,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_lhs,
    output logic [WIDTH-1:0] out_rhs,
    output logic [OPW-1:0]   out_op
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] lhs;
        logic [WIDTH-1:0] rhs;
        logic [OPW-1:0]   op;
        logic [REGW-1:0]  lhs_id;
        logic [REGW-1:0]  rhs_id;
    } slot_t;

    // Replace any operand whose source GPR is being written this edge.
    function automatic slot_t snoop(input slot_t s, input logic v,
                                    input logic [REGW-1:0] id, input logic [WIDTH-1:0] d);
        slot_t r;
        r     = s;
        r.lhs = (v && (s.lhs_id == id)) ? d : s.lhs;
        r.rhs = (v && (s.rhs_id == id)) ? d : s.rhs;
        return r;
    endfunction

    state_t r_state;
    state_t w_nxt_state;
    logic   r_in_ready;
    logic   r_out_valid;
    slot_t  r_o;
    slot_t  r_s;
    slot_t  w_nxt_o;
    slot_t  w_nxt_s;
    slot_t  w_cap;
    logic   w_push;
    logic   w_pop;

    assign w_push = in_valid & r_in_ready;
    assign w_pop  = r_out_valid & out_ready;

    // Incoming entry, with the same-cycle writeback forwarded into it.
    always_comb begin
        w_cap = snoop('{lhs: lhs_bus, rhs: rhs_bus, op: in_op,
                        lhs_id: in_lhs_id, rhs_id: in_rhs_id},
                      wb_valid, wb_id, wb_data);
    end

    // Next state and slot contents; flush overrides everything else.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_o     = r_o;
        w_nxt_s     = r_s;
        if (flush) begin
            w_nxt_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_nxt_state = ST_ONE;
                        w_nxt_o     = w_cap;
                    end else begin
                        w_nxt_state = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (w_push && !w_pop) begin
                        w_nxt_state = ST_TWO;
                        w_nxt_o     = snoop(r_o, wb_valid, wb_id, wb_data);
                        w_nxt_s     = w_cap;
                    end else if (w_push && w_pop) begin
                        w_nxt_state = ST_ONE;
                        w_nxt_o     = w_cap;
                    end else if (w_pop) begin
                        w_nxt_state = ST_EMPTY;
                    end else begin
                        w_nxt_state = ST_ONE;
                        w_nxt_o     = snoop(r_o, wb_valid, wb_id, wb_data);
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        // Skid entry advances; the popped output entry leaves untouched.
                        w_nxt_state = ST_ONE;
                        w_nxt_o     = snoop(r_s, wb_valid, wb_id, wb_data);
                    end else begin
                        w_nxt_state = ST_TWO;
                        w_nxt_o     = snoop(r_o, wb_valid, wb_id, wb_data);
                        w_nxt_s     = snoop(r_s, wb_valid, wb_id, wb_data);
                    end
                end
                default: begin
                    w_nxt_state = ST_EMPTY;
                end
            endcase
        end
    end

    // State, handshake flags and slot storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_o         <= '0;
            r_s         <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_in_ready  <= (w_nxt_state != ST_TWO);
            r_out_valid <= (w_nxt_state != ST_EMPTY);
            r_o         <= w_nxt_o;
            r_s         <= w_nxt_s;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_lhs   = r_o.lhs;
    assign out_rhs   = r_o.rhs;
    assign out_op    = r_o.op;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage.
module tb_alu_operand_stage;

    logic       clk;
    logic       rst;
    logic [7:0] lhs_bus;
    logic [7:0] rhs_bus;
    logic [3:0] in_op;
    logic [1:0] in_lhs_id;
    logic [1:0] in_rhs_id;
    logic       in_valid;
    logic       in_ready;
    logic       wb_valid;
    logic [1:0] wb_id;
    logic [7:0] wb_data;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_lhs;
    logic [7:0] out_rhs;
    logic [3:0] out_op;

    int checks   = 0;
    int failures = 0;

    alu_operand_stage #(.WIDTH(8), .OPW(4), .REGW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .lhs_bus   (lhs_bus),
        .rhs_bus   (rhs_bus),
        .in_op     (in_op),
        .in_lhs_id (in_lhs_id),
        .in_rhs_id (in_rhs_id),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wb_valid  (wb_valid),
        .wb_id     (wb_id),
        .wb_data   (wb_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lhs   (out_lhs),
        .out_rhs   (out_rhs),
        .out_op    (out_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] l, input logic [7:0] r,
                         input logic [3:0] op, input logic [1:0] lid, input logic [1:0] rid);
        in_valid  = v;
        lhs_bus   = l;
        rhs_bus   = r;
        in_op     = op;
        in_lhs_id = lid;
        in_rhs_id = rid;
    endtask

    task automatic check_out(input string tag, input logic [7:0] l, input logic [7:0] r,
                             input logic [3:0] op);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_lhs"}, {24'd0, out_lhs}, {24'd0, l});
        check({tag, "_rhs"}, {24'd0, out_rhs}, {24'd0, r});
        check({tag, "_op"}, {28'd0, out_op}, {28'd0, op});
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        wb_valid = 1'b0; wb_id = 2'd0; wb_data = 8'h00;
        drive(1'b1, 8'hEE, 8'hDD, 4'hF, 2'd0, 2'd1);

        // 1: reset, with an input offered that must be lost
        step(); step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_lhs", {24'd0, out_lhs}, 32'd0);
        check("rst_rhs", {24'd0, out_rhs}, 32'd0);
        check("rst_op", {28'd0, out_op}, 32'd0);
        rst = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 4'h0, 2'd0, 2'd1);
        step();
        check("rst_no_stale", {31'd0, out_valid}, 32'd0);

        // 2: full throughput with out_ready high
        out_ready = 1'b1;
        drive(1'b1, 8'h12, 8'h34, 4'd3, 2'd0, 2'd1);
        step();
        check_out("tp_a", 8'h12, 8'h34, 4'd3);
        check("tp_a_in_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 8'h56, 8'h78, 4'd5, 2'd0, 2'd1);
        step();
        check_out("tp_b", 8'h56, 8'h78, 4'd5);
        check("tp_b_in_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b0, 8'h00, 8'h00, 4'd0, 2'd0, 2'd1);
        step();
        check("tp_drain", {31'd0, out_valid}, 32'd0);

        // 3: back-pressure fills the skid slot, then drains in order
        out_ready = 1'b0;
        drive(1'b1, 8'h01, 8'h01, 4'd1, 2'd0, 2'd1);
        step();
        check_out("bp_a", 8'h01, 8'h01, 4'd1);
        check("bp_one_in_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 8'h02, 8'h02, 4'd2, 2'd0, 2'd1);
        step();
        check_out("bp_hold_a", 8'h01, 8'h01, 4'd1);
        check("bp_two_in_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 8'h03, 8'h03, 4'd3, 2'd0, 2'd1);
        step();
        check_out("bp_still_a", 8'h01, 8'h01, 4'd1);
        drive(1'b0, 8'h00, 8'h00, 4'd0, 2'd0, 2'd1);
        out_ready = 1'b1;
        step();
        check_out("bp_b", 8'h02, 8'h02, 4'd2);
        check("bp_ready_back", {31'd0, in_ready}, 32'd1);
        step();
        check("bp_drain", {31'd0, out_valid}, 32'd0);

        // 4: capture forwarding from the writeback path
        out_ready = 1'b0;
        drive(1'b1, 8'h10, 8'h20, 4'd4, 2'd2, 2'd3);
        wb_valid = 1'b1; wb_id = 2'd2; wb_data = 8'hAA;
        step();
        check_out("fwd", 8'hAA, 8'h20, 4'd4);
        wb_valid = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 4'd0, 2'd0, 2'd1);
        out_ready = 1'b1;
        step();
        check("fwd_drain", {31'd0, out_valid}, 32'd0);

        // 5: snoop both slots while stalled in TWO
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 8'h22, 4'd6, 2'd0, 2'd1);
        step();
        drive(1'b1, 8'h33, 8'h44, 4'd7, 2'd1, 2'd2);
        step();
        drive(1'b0, 8'h00, 8'h00, 4'd0, 2'd0, 2'd0);
        wb_valid = 1'b1; wb_id = 2'd1; wb_data = 8'h5C;
        step();
        wb_valid = 1'b0;
        check_out("snp_o", 8'h11, 8'h5C, 4'd6);
        check("snp_in_ready", {31'd0, in_ready}, 32'd0);
        // popped entry keeps its value; a same-edge writeback only reaches the advancing entry
        out_ready = 1'b1;
        wb_valid = 1'b1; wb_id = 2'd2; wb_data = 8'h99;
        step();
        wb_valid = 1'b0;
        check_out("snp_s", 8'h5C, 8'h99, 4'd7);
        step();
        check("snp_drain", {31'd0, out_valid}, 32'd0);

        // 6: flush from TWO with input offered
        out_ready = 1'b0;
        drive(1'b1, 8'hA1, 8'hA2, 4'd8, 2'd0, 2'd1);
        step();
        drive(1'b1, 8'hB1, 8'hB2, 4'd9, 2'd0, 2'd1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_out_valid", {31'd0, out_valid}, 32'd0);
        check("fl_in_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b0, 8'h00, 8'h00, 4'd0, 2'd0, 2'd1);
        out_ready = 1'b1;
        step();
        check("fl_no_stale", {31'd0, out_valid}, 32'd0);

        // flush from ONE discards an accepted-looking push
        out_ready = 1'b0;
        drive(1'b1, 8'hC1, 8'hC2, 4'd10, 2'd0, 2'd1);
        step();
        drive(1'b1, 8'hD1, 8'hD2, 4'd11, 2'd0, 2'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 4'd0, 2'd0, 2'd1);
        check("fl1_out_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        step();
        check("fl1_no_stale", {31'd0, out_valid}, 32'd0);

        // reset mid-operation discards held entries
        out_ready = 1'b0;
        drive(1'b1, 8'hE1, 8'hE2, 4'd12, 2'd0, 2'd1);
        step();
        drive(1'b0, 8'h00, 8'h00, 4'd0, 2'd0, 2'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_lhs", {24'd0, out_lhs}, 32'd0);
        check("mrst_in_ready", {31'd0, in_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
